// File: rtl/pkt_pkg.sv
// Shared types for the packet transmit FIFO: framing states, the default
// FIFO entry layout and a small saturating-counter helper.
package pkt_pkg;

  localparam int unsigned PKT_DATA_W = 64;
  localparam int unsigned PKT_MOD_W  = $clog2(PKT_DATA_W / 8);

  // Write-side framing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_DROP   = 2'd2
  } frm_state_t;

  // Entry layout at the default width; the top builds the same layout at its
  // own DATA_W/MOD_W and hands it to the storage FIFO as a type parameter.
  typedef struct packed {
    logic [PKT_DATA_W-1:0] data;
    logic [PKT_MOD_W-1:0]  mod;
    logic                  sop;
    logic                  eop;
    logic                  err;
  } pkt_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always visible on rd_data,
// rd_en pops it. Storage is not reset; pointers and level are.
module pkt_sync_fifo
  import pkt_pkg::*;
#(
  parameter type         entry_t = pkt_entry_t,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  entry_t                   wr_data,
  input  logic                     rd_en,
  output entry_t                   rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_wr;
  logic            do_rd;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      level <= level + 1'b1;
      else if (!do_wr && do_rd) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/pkt_tx_fifo.sv
// Packet transmit FIFO: write-side framing checker with drop accounting,
// show-ahead read side in cut-through or store-and-forward mode.
module pkt_tx_fifo
  import pkt_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MOD_W       = $clog2(DATA_W / 8),
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned FULL_THRESH = DEPTH - 4,
  parameter bit          STORE_FWD   = 1'b0
) (
  input  logic                     clk_156m25,
  input  logic                     reset_156m25_n,
  input  logic                     pkt_tx_val,
  input  logic                     pkt_tx_sop,
  input  logic                     pkt_tx_eop,
  input  logic [MOD_W-1:0]         pkt_tx_mod,
  input  logic [DATA_W-1:0]        pkt_tx_data,
  output logic                     pkt_tx_full,
  output logic                     out_val,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     out_err,
  output logic [MOD_W-1:0]         out_mod,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [$clog2(DEPTH):0]   pkt_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  mod;
    logic              sop;
    logic              eop;
    logic              err;
  } entry_t;

  frm_state_t state_q;
  frm_state_t state_d;
  entry_t     wr_entry;
  entry_t     head;
  logic       wr_en;
  logic       drop_word;
  logic       rd_en;
  logic       fifo_empty;
  logic       fifo_full;
  logic       cnt_inc;
  logic       cnt_dec;

  pkt_sync_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk_156m25),
    .rst_n   (reset_156m25_n),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (head),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Framing decision for the incoming word: write, drop, and next state.
  // An overflowing word starts a DROP run unless it is itself the eop.
  // A sop inside a packet closes that packet as an errored eop word; its
  // sop flag is cleared because it belongs to the packet it terminates.
  always_comb begin
    state_d       = state_q;
    wr_en         = 1'b0;
    drop_word     = 1'b0;
    wr_entry.data = pkt_tx_data;
    wr_entry.mod  = pkt_tx_eop ? pkt_tx_mod : {MOD_W{1'b0}};
    wr_entry.sop  = pkt_tx_sop;
    wr_entry.eop  = pkt_tx_eop;
    wr_entry.err  = 1'b0;
    if (pkt_tx_val) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!pkt_tx_sop) begin
            drop_word = 1'b1;
          end else if (fifo_full) begin
            drop_word = 1'b1;
            state_d   = pkt_tx_eop ? ST_IDLE : ST_DROP;
          end else begin
            wr_en   = 1'b1;
            state_d = pkt_tx_eop ? ST_IDLE : ST_IN_PKT;
          end
        end
        ST_IN_PKT: begin
          if (pkt_tx_sop) begin
            wr_entry.sop = 1'b0;
            wr_entry.eop = 1'b1;
            wr_entry.err = 1'b1;
            wr_entry.mod = '0;
          end
          if (fifo_full) begin
            drop_word = 1'b1;
            state_d   = pkt_tx_eop ? ST_IDLE : ST_DROP;
          end else begin
            wr_en   = 1'b1;
            state_d = (pkt_tx_sop || pkt_tx_eop) ? ST_IDLE : ST_IN_PKT;
          end
        end
        ST_DROP: begin
          drop_word = 1'b1;
          if (pkt_tx_eop) state_d = ST_IDLE;
        end
        default: begin
          drop_word = 1'b1;
          state_d   = ST_IDLE;
        end
      endcase
    end
  end

  // Read side: show-ahead head, gated on completed packets in store-and-forward
  // mode unless the FIFO is completely full (would otherwise deadlock).
  assign out_val  = !fifo_empty && (!STORE_FWD || (pkt_cnt != '0) || fifo_full);
  assign rd_en    = out_val & out_ready;
  assign out_data = out_val ? head.data : '0;
  assign out_mod  = out_val ? head.mod  : '0;
  assign out_sop  = out_val & head.sop;
  assign out_eop  = out_val & head.eop;
  assign out_err  = out_val & head.err;

  assign cnt_inc = wr_en & wr_entry.eop;
  assign cnt_dec = rd_en & head.eop;

  // Framing state register.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // Complete-packet count: +1 per stored eop, -1 per eop read.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      pkt_cnt <= '0;
    end else begin
      unique case ({cnt_inc, cnt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Saturating count of discarded words.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n)  drop_cnt <= '0;
    else if (drop_word)   drop_cnt <= sat_inc16(drop_cnt);
  end

  // Registered almost-full, lagging the level by one cycle.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) pkt_tx_full <= 1'b0;
    else                 pkt_tx_full <= (fifo_level >= LVL_W'(FULL_THRESH));
  end

endmodule

// File: tb/tb_pkt_tx_fifo.sv
// Bench for pkt_tx_fifo: a cut-through and a store-and-forward instance share
// the write stimulus; a packet-level model predicts stored words and counters,
// and a negedge monitor compares each instance against its model queue.
`timescale 1ns/1ps
module tb_pkt_tx_fifo;

  localparam int DW     = 64;
  localparam int MW     = 3;
  localparam int DEPTH  = 16;
  localparam int THRESH = 12;
  localparam int M_IDLE = 0;
  localparam int M_IN   = 1;
  localparam int M_DROP = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [MW-1:0] mod;
    logic          sop;
    logic          eop;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_val = 1'b0;
  logic          tx_sop = 1'b0;
  logic          tx_eop = 1'b0;
  logic [MW-1:0] tx_mod = '0;
  logic [DW-1:0] tx_data = '0;
  logic [1:0]    rdy = 2'b00;

  logic [1:0]    o_val, o_sop, o_eop, o_err, o_full;
  logic [MW-1:0] o_mod  [2];
  logic [DW-1:0] o_data [2];
  logic [4:0]    o_lvl  [2];
  logic [4:0]    o_pkt  [2];
  logic [15:0]   o_drop [2];

  exp_t exp_q [2][$];
  int   m_state [2];
  int   m_pkts [2];
  int   m_drops [2];
  int   prev_size [2];
  bit   pend_wr [2];
  bit   pend_drop [2];
  exp_t pend_e [2];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;

  always #3.2 clk = ~clk;

  pkt_tx_fifo #(.DATA_W(DW), .MOD_W(MW), .DEPTH(DEPTH), .FULL_THRESH(THRESH), .STORE_FWD(1'b0)) u_ct (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .pkt_tx_val(tx_val), .pkt_tx_sop(tx_sop), .pkt_tx_eop(tx_eop), .pkt_tx_mod(tx_mod), .pkt_tx_data(tx_data),
    .pkt_tx_full(o_full[0]), .out_val(o_val[0]), .out_sop(o_sop[0]), .out_eop(o_eop[0]), .out_err(o_err[0]),
    .out_mod(o_mod[0]), .out_data(o_data[0]), .out_ready(rdy[0]),
    .fifo_level(o_lvl[0]), .pkt_cnt(o_pkt[0]), .drop_cnt(o_drop[0]));

  pkt_tx_fifo #(.DATA_W(DW), .MOD_W(MW), .DEPTH(DEPTH), .FULL_THRESH(THRESH), .STORE_FWD(1'b1)) u_sf (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .pkt_tx_val(tx_val), .pkt_tx_sop(tx_sop), .pkt_tx_eop(tx_eop), .pkt_tx_mod(tx_mod), .pkt_tx_data(tx_data),
    .pkt_tx_full(o_full[1]), .out_val(o_val[1]), .out_sop(o_sop[1]), .out_eop(o_eop[1]), .out_err(o_err[1]),
    .out_mod(o_mod[1]), .out_data(o_data[1]), .out_ready(rdy[1]),
    .fifo_level(o_lvl[1]), .pkt_cnt(o_pkt[1]), .drop_cnt(o_drop[1]));

  task automatic check(input string name, input int inst, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got 0x%0h, required 0x%0h", name, inst, $time, act, req);
    end
  endtask

  // Per-instance comparison against the model; pops when the model says a
  // word transfers at the coming edge.
  task automatic monitor(input int i);
    bit   ev;
    exp_t act;
    exp_t h;
    int   sz;
    sz = exp_q[i].size();
    h  = (sz != 0) ? exp_q[i][0] : '0;
    ev = (sz != 0) && ((i == 0) || (m_pkts[i] > 0) || (sz == DEPTH));
    act.data = o_data[i];
    act.mod  = o_mod[i];
    act.sop  = o_sop[i];
    act.eop  = o_eop[i];
    act.err  = o_err[i];
    check("out_val", i, 128'(o_val[i]), 128'(ev));
    if (ev) check("head_word", i, 128'(act), 128'(h));
    else    check("idle_zero", i, 128'(act), 128'(0));
    check("fifo_level", i, 128'(o_lvl[i]), 128'(sz));
    check("pkt_cnt", i, 128'(o_pkt[i]), 128'(m_pkts[i]));
    check("drop_cnt", i, 128'(o_drop[i]), 128'(m_drops[i]));
    check("pkt_tx_full", i, 128'(o_full[i]), 128'(prev_size[i] >= THRESH));
    prev_size[i] = sz;
    if (ev && rdy[i]) begin
      if (h.eop) m_pkts[i]--;
      void'(exp_q[i].pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) monitor(i);
    end
  end

  // Apply the previous cycle's predicted write/drop (it happened at this edge).
  task automatic commit();
    for (int i = 0; i < 2; i++) begin
      if (pend_wr[i]) begin
        exp_q[i].push_back(pend_e[i]);
        if (pend_e[i].eop) m_pkts[i]++;
      end
      if (pend_drop[i] && m_drops[i] < 65535) m_drops[i]++;
      pend_wr[i]   = 1'b0;
      pend_drop[i] = 1'b0;
    end
  endtask

  // Packet rules: words outside a packet or in a dropped packet are discarded;
  // a sop inside a packet terminates it with an errored eop word; a word with
  // no room is discarded and the rest of its packet follows it.
  task automatic decide(input int i);
    exp_t e;
    bit   room;
    room = exp_q[i].size() < DEPTH;
    if (!tx_val) return;
    if (m_state[i] == M_DROP) begin
      pend_drop[i] = 1'b1;
      if (tx_eop) m_state[i] = M_IDLE;
      return;
    end
    if (m_state[i] == M_IDLE && !tx_sop) begin
      pend_drop[i] = 1'b1;
      return;
    end
    if (m_state[i] == M_IN && tx_sop) begin
      e.data = tx_data; e.mod = '0; e.sop = 1'b0; e.eop = 1'b1; e.err = 1'b1;
    end else begin
      e.data = tx_data; e.mod = tx_eop ? tx_mod : '0; e.sop = tx_sop; e.eop = tx_eop; e.err = 1'b0;
    end
    if (!room) begin
      pend_drop[i] = 1'b1;
      m_state[i]   = tx_eop ? M_IDLE : M_DROP;
    end else begin
      pend_wr[i]   = 1'b1;
      pend_e[i]    = e;
      m_state[i]   = e.eop ? M_IDLE : M_IN;
    end
  endtask

  task automatic drive(input bit v, input bit s, input bit e, input logic [MW-1:0] m);
    @(posedge clk); #1;
    commit();
    tx_val  = v;
    tx_sop  = s;
    tx_eop  = e;
    tx_mod  = m;
    tx_data = {$urandom, $urandom};
    case (rdy_mode)
      0:       rdy = 2'b11;
      1:       rdy = 2'b00;
      default: rdy = 2'($urandom);
    endcase
    for (int i = 0; i < 2; i++) decide(i);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_pkt(input int len, input logic [MW-1:0] m);
    for (int k = 0; k < len; k++)
      drive(1'b1, k == 0, k == len - 1, (k == len - 1) ? m : MW'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n  = 1'b0;
    tx_val = 1'b0;
    tx_sop = 1'b0;
    tx_eop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      m_state[i] = M_IDLE; m_pkts[i] = 0; m_drops[i] = 0; prev_size[i] = 0;
      pend_wr[i] = 1'b0; pend_drop[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_out_val", i, 128'(o_val[i]), 128'(0));
      check("rst_out_data", i, 128'(o_data[i]), 128'(0));
      check("rst_level", i, 128'(o_lvl[i]), 128'(0));
      check("rst_pkt_cnt", i, 128'(o_pkt[i]), 128'(0));
      check("rst_drop_cnt", i, 128'(o_drop[i]), 128'(0));
      check("rst_full", i, 128'(o_full[i]), 128'(0));
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Three-word packet, mod 5 on the eop word, reader always ready.
    rdy_mode = 0;
    send_pkt(3, 3'd5);
    idle(4);

    // Four-word packet with two idle cycles mid-packet.
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd6);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 3'd1);
    drive(1'b1, 1'b0, 1'b1, 3'd7);
    idle(6);

    // Overflow: 20 words into a stalled reader.
    do_reset();
    rdy_mode = 1;
    send_pkt(20, 3'd3);
    idle(2);
    for (int i = 0; i < 2; i++) begin
      check("ovf_drop_cnt", i, 128'(o_drop[i]), 128'(4));
      check("ovf_full", i, 128'(o_full[i]), 128'(1));
      check("ovf_level", i, 128'(o_lvl[i]), 128'(16));
    end
    rdy_mode = 0;
    idle(20);

    // Framing errors: stray word, then sop,w,sop,w,eop.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 3'd2);
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 1'b1, 1'b0, 3'd4);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 1'b1, 3'd1);
    idle(6);
    for (int i = 0; i < 2; i++) check("frm_drop_cnt", i, 128'(o_drop[i]), 128'(3));

    // Oversized packet in store-and-forward: release at full level.
    do_reset();
    rdy_mode = 1;
    send_pkt(17, 3'd2);
    rdy_mode = 0;
    idle(4);
    send_pkt(2, 3'd1);
    idle(30);

    // Reset mid-packet, then a single-word packet.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    do_reset();
    send_pkt(1, 3'd4);
    idle(5);

    // Random traffic with occasional malformed framing and random backpressure.
    rdy_mode = 2;
    for (int p = 0; p < 300; p++) begin
      int len;
      len = int'($urandom_range(1, 24));
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < len; k++)
          drive(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), MW'($urandom));
      end else begin
        send_pkt(len, MW'($urandom));
      end
      idle(int'($urandom_range(0, 2)));
    end
    rdy_mode = 0;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
